round_score_controller: RTL and testbench

//  Round/match sequencer for the TicTacToe score datapath. Watches the board

---
 rtl/round_score_controller_if.sv | 23 ++
 rtl/round_score_controller.sv | 74 +++++++
 tb/tb_round_score_controller.sv | 114 +++++++++++
 3 files changed

// File: rtl/round_score_controller_if.sv
// round_score_controller_if: board/score-side signals of the round sequencer.
interface round_score_controller_if;
   logic       win_x;
   logic       win_o;
   logic       draw;
   logic       board_clear_ack;
   logic       new_match;
   logic       incrementX;
   logic       incrementO;
   logic       resetScore;
   logic       clear_board_req;
   logic       round_active;
   logic       match_over;
   logic [1:0] winner;
   modport master (
      output win_x, win_o, draw, board_clear_ack, new_match,
      input  incrementX, incrementO, resetScore, clear_board_req, round_active, match_over, winner
   );
   modport slave (
      input  win_x, win_o, draw, board_clear_ack, new_match,
      output incrementX, incrementO, resetScore, clear_board_req, round_active, match_over, winner
   );
endinterface

// File: rtl/round_score_controller.sv
// round_score_controller: credits round winners, holds the result, clears the board, ends the match.
module round_score_controller #(
   parameter int WIN_TARGET  = 10,
   parameter int HOLD_CYCLES = 100_000_000,
   parameter int CNT_W       = 6
) (
   input logic CLK_100MHZ,
   input logic reset,
   round_score_controller_if.slave bus
);
   localparam int TW = $clog2(HOLD_CYCLES + 1);
   typedef enum logic [2:0] {PLAY, CREDIT, HOLD, CLEAR, MATCH_OVER, RESTART} state_t;
   state_t           state, nxt;
   logic [1:0]       win_nxt;
   logic [CNT_W-1:0] wins_x, wins_o;
   logic [TW-1:0]    timer;
   logic             flag, expired, done, cr_x, cr_o;
   assign flag    = bus.win_x | bus.win_o | bus.draw;
   assign expired = timer == TW'(HOLD_CYCLES - 1);
   assign done    = wins_x == CNT_W'(WIN_TARGET) || wins_o == CNT_W'(WIN_TARGET);
   assign cr_x    = nxt == CREDIT && win_nxt == 2'b01;
   assign cr_o    = nxt == CREDIT && win_nxt == 2'b10;
   // new_match overrides everything, including a flag seen in the same cycle
   always_comb begin
      nxt     = state;
      win_nxt = bus.winner;
      if (bus.new_match) begin
         nxt     = RESTART;
         win_nxt = 2'b00;
      end else begin
         case (state)
            PLAY: if (flag) begin
               nxt     = CREDIT;
               win_nxt = (bus.win_x & ~bus.win_o) ? 2'b01 : (bus.win_o & ~bus.win_x) ? 2'b10 : 2'b11;
            end
            CREDIT:  nxt = HOLD;
            HOLD:    if (expired) nxt = done ? MATCH_OVER : CLEAR;
            CLEAR:   if (bus.board_clear_ack && !flag) begin
               nxt     = PLAY;
               win_nxt = 2'b00;
            end
            RESTART: nxt = CLEAR;
            default: nxt = state;
         endcase
      end
   end
   always_ff @(posedge CLK_100MHZ or posedge reset) begin
      if (reset) begin
         state               <= PLAY;
         wins_x              <= '0;
         wins_o              <= '0;
         timer               <= '0;
         bus.winner          <= 2'b00;
         bus.incrementX      <= 1'b0;
         bus.incrementO      <= 1'b0;
         bus.resetScore      <= 1'b0;
         bus.clear_board_req <= 1'b0;
         bus.round_active    <= 1'b1;
         bus.match_over      <= 1'b0;
      end else begin
         state               <= nxt;
         bus.winner          <= win_nxt;
         bus.incrementX      <= cr_x;
         bus.incrementO      <= cr_o;
         bus.resetScore      <= nxt == RESTART;
         bus.clear_board_req <= nxt == CLEAR;
         bus.round_active    <= nxt == PLAY;
         bus.match_over      <= nxt == MATCH_OVER;
         wins_x              <= nxt == RESTART ? '0 : wins_x + CNT_W'(cr_x && wins_x != '1);
         wins_o              <= nxt == RESTART ? '0 : wins_o + CNT_W'(cr_o && wins_o != '1);
         timer               <= (state == HOLD && nxt == HOLD) ? timer + 1'b1 : '0;
      end
   end
endmodule

// File: tb/tb_round_score_controller.sv
// tb_round_score_controller: table-driven scoreboard bench with WIN_TARGET=2, HOLD_CYCLES=4.
module tb_round_score_controller;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_run = 0;
   int   n_fail = 0;
   round_score_controller_if bus ();
   round_score_controller #(.WIN_TARGET(2), .HOLD_CYCLES(4), .CNT_W(6)) dut (
      .CLK_100MHZ(clk),
      .reset(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // packed outputs: {incX, incO, resetScore, clear_req, round_active, match_over, winner}
   localparam logic [7:0] PLY = 8'b0000_1000, CRX = 8'b1000_0001, HDX = 8'b0000_0001,
                          CLX = 8'b0001_0001, CRD = 8'b0000_0011, HDD = 8'b0000_0011,
                          CLD = 8'b0001_0011, CRO = 8'b0100_0010, HDO = 8'b0000_0010,
                          RST = 8'b0010_0000, CLN = 8'b0001_0000, MOX = 8'b0000_0101;
   typedef struct {
      logic [4:0] in;
      logic [7:0] o;
      logic [5:0] nx;
      logic [5:0] no;
   } vec_t;
   typedef struct {
      logic [7:0] o;
      logic [5:0] nx;
      logic [5:0] no;
   } exp_t;
   vec_t tab[$];
   exp_t sb[$];
   function automatic logic [7:0] outs();
      return {bus.incrementX, bus.incrementO, bus.resetScore, bus.clear_board_req,
              bus.round_active, bus.match_over, bus.winner};
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   // in = {win_x, win_o, draw, ack, new_match}
   task automatic add(input logic [4:0] in, input logic [7:0] o, input logic [5:0] nx, input logic [5:0] no);
      tab.push_back('{in, o, nx, no});
   endtask
   task automatic drive(input logic [4:0] in);
      {bus.win_x, bus.win_o, bus.draw, bus.board_clear_ack, bus.new_match} = in;
   endtask
   initial begin
      int n;
      exp_t e;
      add(5'b00000, PLY, 0, 0); add(5'b10000, CRX, 1, 0); add(5'b00000, HDX, 1, 0);
      add(5'b10000, HDX, 1, 0); add(5'b00000, HDX, 1, 0); add(5'b00000, HDX, 1, 0);
      add(5'b00000, CLX, 1, 0); add(5'b01010, CLX, 1, 0); add(5'b00010, PLY, 1, 0);
      add(5'b11000, CRD, 1, 0);
      for (int i = 0; i < 4; i++) add(5'b00000, HDD, 1, 0);
      add(5'b00000, CLD, 1, 0); add(5'b00010, PLY, 1, 0); add(5'b00100, CRD, 1, 0);
      for (int i = 0; i < 4; i++) add(5'b00000, HDD, 1, 0);
      add(5'b00000, CLD, 1, 0); add(5'b00010, PLY, 1, 0); add(5'b01000, CRO, 1, 1);
      add(5'b00000, HDO, 1, 1); add(5'b00001, RST, 0, 0); add(5'b00000, CLN, 0, 0);
      add(5'b00010, PLY, 0, 0); add(5'b01001, RST, 0, 0); add(5'b00000, CLN, 0, 0);
      add(5'b00010, PLY, 0, 0); add(5'b10000, CRX, 1, 0);
      for (int i = 0; i < 4; i++) add(5'b00000, HDX, 1, 0);
      add(5'b00000, CLX, 1, 0); add(5'b00010, PLY, 1, 0); add(5'b10000, CRX, 2, 0);
      for (int i = 0; i < 4; i++) add(5'b00000, HDX, 2, 0);
      add(5'b00000, MOX, 2, 0); add(5'b10000, MOX, 2, 0); add(5'b00001, RST, 0, 0);
      add(5'b00000, CLN, 0, 0); add(5'b00010, PLY, 0, 0);
      drive(5'b00000);
      repeat (2) cyc();
      chk("reset_outs", 32'(outs()), 32'(PLY));
      chk("reset_wins", 32'({dut.wins_x, dut.wins_o}), 0);
      rst = 1'b0;
      foreach (tab[i]) begin
         drive(tab[i].in);
         sb.push_back('{tab[i].o, tab[i].nx, tab[i].no});
         cyc();
         e = sb.pop_front();
         chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(e.o));
         chk($sformatf("vec%0d_wins", i), 32'({dut.wins_x, dut.wins_o}), 32'({e.nx, e.no}));
      end
      drive(5'b10000);
      cyc();
      drive(5'b00000);
      chk("credit_incx", 32'(bus.incrementX), 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_credit_incx", 32'(bus.incrementX), 0);
      chk("rst_mid_credit_active", 32'(bus.round_active), 1);
      chk("rst_mid_credit_wins", 32'({dut.wins_x, dut.wins_o}), 0);
      cyc();
      rst = 1'b0;
      drive(5'b10000);
      cyc();
      drive(5'b00000);
      chk("hold_credit_outs", 32'(outs()), 32'(CRX));
      n = 0;
      while (!bus.clear_board_req && n < 20) begin
         cyc();
         chk($sformatf("hold_no_double_inc%0d", n), 32'({bus.incrementX, bus.incrementO}), 0);
         n++;
      end
      chk("hold_to_clear_cycles", 32'(n), 5);
      drive(5'b00010);
      cyc();
      chk("hold_back_to_play", 32'(outs()), 32'(PLY));
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
